// File: rtl/lane_arb_pkg.sv
// lane_arb_pkg: shared state encoding and width helper for the lane round-robin arbiter.
package lane_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int cnt_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: one-hot pick of the first requester at or after ptr, wrapping upward.
module rr_priority_picker
    import lane_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    localparam int PW = cnt_w(NUM_LANES)
)(
    input  logic [NUM_LANES-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_LANES-1:0] pick,
    output logic                 any
);

    logic [NUM_LANES-1:0] rot;
    logic [NUM_LANES-1:0] first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        rot = '0;
        pick = '0;
        for (int i = 0; i < NUM_LANES; i++) rot[i] = req[PW'((i + int'(ptr)) % NUM_LANES)];
        first = rot & (~rot + NUM_LANES'(1));
        for (int i = 0; i < NUM_LANES; i++) pick[PW'((i + int'(ptr)) % NUM_LANES)] = first[i];
    end

    assign any = |req;

endmodule

// File: rtl/lane_round_robin_arbiter.sv
// lane_round_robin_arbiter: round-robin sharing of one output channel among lanes with burst locking.
module lane_round_robin_arbiter
    import lane_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          in_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   in_data,
    input  logic [NUM_LANES-1:0]          in_last,
    output logic [NUM_LANES-1:0]          in_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [NUM_LANES-1:0]          grant,
    output logic                          busy
);

    localparam int PW = cnt_w(NUM_LANES);
    localparam int BW = cnt_w(MAX_BURST);

    arb_state_t           state_q, state_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_LANES-1:0] pick;
    logic [PW-1:0]        owner;
    logic [DATA_W-1:0]    mux_data;
    logic                 any_req;
    logic                 xfer;

    rr_priority_picker #(.NUM_LANES(NUM_LANES)) u_picker (
        .req  (in_valid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        owner = '0;
        mux_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant_q[i]) begin
                owner = PW'(i);
                mux_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy      = state_q == ARB_GRANT;
    assign grant     = grant_q;
    assign out_valid = busy && |(in_valid & grant_q);
    assign out_data  = busy ? mux_data : '0;
    assign out_last  = busy && (|(in_last & grant_q) || beat_cnt_q == BW'(MAX_BURST - 1));
    assign in_ready  = busy && out_ready ? grant_q : '0;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (any_req) begin
                state_d = ARB_GRANT;
                grant_d = pick;
                beat_cnt_d = '0;
            end
        end else if (xfer) begin
            if (out_last) begin
                state_d = ARB_IDLE;
                grant_d = '0;
                rr_ptr_d = (owner == PW'(NUM_LANES - 1)) ? '0 : owner + PW'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
